cache_controller: RTL and testbench

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_controller.sv | 162 ++++++++++++++++
 tb/tb_cache_controller.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// 2-way set-associative, read-allocate, write-through cache in front of an SRAM controller.
// Optional read hit/miss statistics are enabled with the CACHE_STATS_EN macro.
module cache_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  input  logic        sram_ready,
  input  logic [31:0] sram_rdata,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  typedef enum logic [1:0] {IDLE, RD0, RD1, WR} state_e;

  state_e            state_q, state_d;
  logic [1:0][63:0]  valid_q;
  logic [63:0]       lru_q;            // per set: the way to replace next
  logic [9:0]        tag_q  [2][64];
  logic [63:0]       data_q [2][64];
  logic [31:0]       word0_q;

  logic        word_sel;
  logic [5:0]  idx;
  logic [9:0]  tag;
  logic        is_wr, is_rd;
  logic [1:0]  hit_way;
  logic        hit, hit_sel, victim, fill_done;
  logic [63:0] hit_line;

  assign word_sel  = address[2];
  assign idx       = address[8:3];
  assign tag       = address[18:9];
  assign is_wr     = MEM_W_EN;
  assign is_rd     = MEM_R_EN & ~MEM_W_EN;
  assign hit_way[0] = valid_q[0][idx] && (tag_q[0][idx] == tag);
  assign hit_way[1] = valid_q[1][idx] && (tag_q[1][idx] == tag);
  assign hit       = |hit_way;
  assign hit_sel   = hit_way[1];
  assign hit_line  = data_q[hit_sel][idx];
  assign victim    = !valid_q[0][idx] ? 1'b0 :
                     !valid_q[1][idx] ? 1'b1 : lru_q[idx];
  assign fill_done = (state_q == RD1) && sram_ready;

  // Outputs are decoded from the state so a hit or the final SRAM beat completes in the same cycle.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a latch behind.
    state_d      = state_q;
    ready        = 1'b1;
    rdata        = '0;
    sram_rd_en   = 1'b0;
    sram_wr_en   = 1'b0;
    sram_address = '0;
    sram_wdata   = '0;
    case (state_q)
      IDLE: begin
        if (is_wr) begin
          ready   = 1'b0;
          state_d = WR;
        end else if (is_rd) begin
          if (hit) begin
            rdata = word_sel ? hit_line[63:32] : hit_line[31:0];
          end else begin
            ready   = 1'b0;
            state_d = RD0;
          end
        end
      end
      RD0: begin
        ready        = 1'b0;
        sram_rd_en   = 1'b1;
        sram_address = {address[31:3], 3'b000};
        if (sram_ready) state_d = RD1;
      end
      RD1: begin
        sram_rd_en   = 1'b1;
        sram_address = {address[31:3], 3'b100};
        ready        = sram_ready;
        if (sram_ready) begin
          rdata   = word_sel ? sram_rdata : word0_q;
          state_d = IDLE;
        end
      end
      WR: begin
        sram_wr_en   = 1'b1;
        sram_address = address;
        sram_wdata   = wdata;
        ready        = sram_ready;
        if (sram_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      state_d      = IDLE;
      ready        = 1'b1;
      rdata        = '0;
      sram_rd_en   = 1'b0;
      sram_wr_en   = 1'b0;
      sram_address = '0;
      sram_wdata   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      lru_q   <= '0;
      word0_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == RD0 && sram_ready) word0_q <= sram_rdata;
      if (state_q == IDLE && is_rd && hit) lru_q[idx] <= ~hit_sel;
      if (state_q == IDLE && is_wr) begin
        if (hit_way[0]) valid_q[0][idx] <= 1'b0;
        if (hit_way[1]) valid_q[1][idx] <= 1'b0;
      end
      if (fill_done) begin
        valid_q[victim][idx] <= 1'b1;
        lru_q[idx]           <= ~victim;
      end
    end
  end

  // NOTE: tag and data arrays have no reset; the valid bits alone decide whether they are used.
  always_ff @(posedge clk) begin
    if (!rst && fill_done) begin
      tag_q[victim][idx]  <= tag;
      data_q[victim][idx] <= {sram_rdata, word0_q};
    end
  end

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == IDLE && is_rd) begin
      if (hit && hit_cnt_q != 16'hFFFF)    hit_cnt_q  <= hit_cnt_q + 16'd1;
      if (!hit && miss_cnt_q != 16'hFFFF)  miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign hit_count  = rst ? 16'h0 : hit_cnt_q;
  assign miss_count = rst ? 16'h0 : miss_cnt_q;
`else
  assign hit_count  = 16'h0;
  assign miss_count = 16'h0;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: transaction-level cache model, behavioural SRAM, per-cycle compare.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MEM_R_EN = 1'b0, MEM_W_EN = 1'b0;
  logic [31:0] address = '0, wdata = '0;
  logic [31:0] rdata, sram_address, sram_wdata;
  logic [31:0] sram_rdata = '0;
  logic        ready, sram_rd_en, sram_wr_en;
  logic        sram_ready = 1'b0;
  logic [15:0] hit_count, miss_count;

  always #5 clk = ~clk;

  cache_controller dut (
    .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
    .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en),
    .sram_ready(sram_ready), .sram_rdata(sram_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

`ifdef CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %08h expected %08h", name, $time, act, exp);
    end
  endtask

  // Behavioural SRAM: each access takes lat cycles of asserted enable.
  int          lat = 1;
  int          acc_cnt = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_log[$];
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    if (mem.exists(k)) return mem[k];
    return {k[15:0] ^ 16'hC0DE, k[15:0]};
  endfunction

  always @(posedge clk) begin
    #1;
    if (sram_ready) acc_cnt = 0;
    if (sram_rd_en || sram_wr_en) begin
      acc_cnt++;
      sram_ready = (acc_cnt >= lat);
    end else begin
      acc_cnt    = 0;
      sram_ready = 1'b0;
    end
    sram_rdata = (sram_ready && sram_rd_en) ? mem_rd(sram_address) : 32'hBAD0_BAD0;
    if (sram_ready && sram_rd_en) rd_log.push_back(sram_address);
    if (sram_ready && sram_wr_en) begin
      wr_addr_log.push_back(sram_address);
      wr_data_log.push_back(sram_wdata);
      mem[{sram_address[31:2], 2'b00}] = sram_wdata;
    end
  end

  // Cache model: set -> two ways, plus the way each set should replace next.
  logic        mv   [64][2];
  logic [9:0]  mt   [64][2];
  logic [31:0] md   [64][2][2];
  logic        mlru [64];
  int          exp_hits, exp_misses;

  function automatic void model_reset();
    for (int s = 0; s < 64; s++) begin
      mv[s][0] = 1'b0;
      mv[s][1] = 1'b0;
      mlru[s]  = 1'b0;
    end
    exp_hits   = 0;
    exp_misses = 0;
  endfunction

  function automatic int model_lookup(input logic [31:0] a);
    for (int w = 0; w < 2; w++)
      if (mv[a[8:3]][w] && mt[a[8:3]][w] == a[18:9]) return w;
    return -1;
  endfunction

  function automatic logic [15:0] stat(input int c);
    return STATS ? ((c > 65535) ? 16'hFFFF : 16'(c)) : 16'h0;
  endfunction

  logic        chk_en = 1'b0;
  logic        exp_ready, exp_rd_en, exp_wr_en, chk_addr, chk_wdata;
  logic [31:0] exp_rdata, exp_addr, exp_wdata;

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", ready, exp_ready);
      check("rdata", rdata, exp_rdata);
      check("sram_rd_en", sram_rd_en, exp_rd_en);
      check("sram_wr_en", sram_wr_en, exp_wr_en);
      if (chk_addr)  check("sram_address", sram_address, exp_addr);
      if (chk_wdata) check("sram_wdata", sram_wdata, exp_wdata);
      check("hit_count", hit_count, stat(exp_hits));
      check("miss_count", miss_count, stat(exp_misses));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_idle();
    exp_ready = 1'b1; exp_rdata = '0; exp_rd_en = 1'b0; exp_wr_en = 1'b0;
    chk_addr  = 1'b0; chk_wdata = 1'b0;
  endtask

  task automatic expect_reset_values();
    expect_idle();
    chk_addr = 1'b1; exp_addr = '0; chk_wdata = 1'b1; exp_wdata = '0;
  endtask

  task automatic idle(input int n);
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    expect_idle();
    repeat (n) next_cycle();
  endtask

  task automatic apply_reset();
    rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    expect_reset_values();
    model_reset();
    #1;
    check("rst_ready", ready, 1);
    check("rst_hit_count", hit_count, 0);
    next_cycle();
    rst = 1'b0;
    expect_reset_values();
    #1;
    check("post_rst_rd_en", sram_rd_en, 0);
    next_cycle();
  endtask

  typedef enum int {K_HIT, K_MISS, K_WR} kind_e;

  // One pipeline request, held until ready; expectations derived from the model each cycle.
  task automatic run_txn(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input bit rst_mid, output logic first_ready, output logic [31:0] got,
                         output int cycles);
    logic [5:0] idx;
    int         way, acc, budget, v, n_acc;
    kind_e      kind;
    logic       done;
    idx  = a[8:3];
    way  = model_lookup(a);
    kind = w ? K_WR : ((way >= 0) ? K_HIT : K_MISS);
    MEM_R_EN = r; MEM_W_EN = w; address = a; wdata = d;
    got = '0; cycles = 1;
    expect_idle();
    if (kind == K_HIT) exp_rdata = md[idx][way][a[2]];
    else               exp_ready = 1'b0;
    #1;
    first_ready = ready;
    if (kind == K_HIT) got = rdata;
    next_cycle();
    case (kind)
      K_HIT:  begin exp_hits++; mlru[idx] = (way == 0); end
      K_MISS: exp_misses++;
      default: begin
        for (int k = 0; k < 2; k++)
          if (mv[idx][k] && mt[idx][k] == a[18:9]) mv[idx][k] = 1'b0;
      end
    endcase
    n_acc  = (kind == K_MISS) ? 2 : ((kind == K_WR) ? 1 : 0);
    acc    = 0;
    budget = 0;
    while (acc < n_acc) begin
      if (kind == K_MISS) begin
        exp_rd_en = 1'b1; exp_wr_en = 1'b0; chk_addr = 1'b1; chk_wdata = 1'b0;
        exp_addr  = {a[31:3], acc[0], 2'b00};
        exp_ready = (acc == 1) && sram_ready;
        exp_rdata = exp_ready ? mem_rd(a) : 32'h0;
        if (rst_mid && acc == 1 && !sram_ready) begin
          rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
          expect_reset_values();
          model_reset();
          next_cycle();
          rst = 1'b0;
          expect_reset_values();
          #1;
          check("rst_mid_ready", ready, 1);
          check("rst_mid_rd_en", sram_rd_en, 0);
          next_cycle();
          return;
        end
      end else begin
        exp_rd_en = 1'b0; exp_wr_en = 1'b1; chk_addr = 1'b1; chk_wdata = 1'b1;
        exp_addr  = a; exp_wdata = d;
        exp_ready = sram_ready; exp_rdata = '0;
      end
      done = sram_ready;
      cycles++;
      #1;
      if (exp_ready) got = rdata;
      next_cycle();
      if (done) acc++;
      budget++;
      if (budget > 200) begin
        n_tests++; n_fail++;
        $display("FAIL txn_timeout addr %08h: no completion within 200 cycles", a);
        return;
      end
    end
    if (kind == K_MISS) begin
      v = !mv[idx][0] ? 0 : (!mv[idx][1] ? 1 : int'(mlru[idx]));
      mv[idx][v]    = 1'b1;
      mt[idx][v]    = a[18:9];
      md[idx][v][0] = mem_rd({a[31:3], 3'b000});
      md[idx][v][1] = mem_rd({a[31:3], 3'b100});
      mlru[idx]     = (v == 0);
    end
    check("latency", cycles, (kind == K_MISS) ? 1 + 2 * lat : ((kind == K_WR) ? 1 + lat : 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        fr;
    logic [31:0] got;
    int          cyc, nrd, nwr;

    next_cycle();
    chk_en = 1'b1;
    apply_reset();

    // Cold read miss
    mem[32'h408] = 32'h1111_1111;
    mem[32'h40C] = 32'h2222_2222;
    lat = 1;
    run_txn(1, 0, 32'h408, 0, 0, fr, got, cyc);
    check("cold_first_ready", fr, 0);
    check("cold_rdata", got, 32'h1111_1111);
    check("cold_latency", cyc, 3);
    check("cold_rd_count", rd_log.size(), 2);
    if (rd_log.size() >= 2) begin
      check("cold_rd0_addr", rd_log[0], 32'h408);
      check("cold_rd1_addr", rd_log[1], 32'h40C);
    end
    check("cold_miss_count", miss_count, STATS ? 32'd1 : 32'd0);

    // Read hit on the other word of the line
    run_txn(1, 0, 32'h40C, 0, 0, fr, got, cyc);
    check("hit_first_ready", fr, 1);
    check("hit_rdata", got, 32'h2222_2222);
    check("hit_rd_count", rd_log.size(), 2);
    check("hit_hit_count", hit_count, STATS ? 32'd1 : 32'd0);
    idle(2);

    // Eviction in set 1
    apply_reset();
    lat = 2;
    run_txn(1, 0, 32'h008, 0, 0, fr, got, cyc);
    check("ev_008_miss", fr, 0);
    run_txn(1, 0, 32'h208, 0, 0, fr, got, cyc);
    check("ev_208_miss", fr, 0);
    run_txn(1, 0, 32'h008, 0, 0, fr, got, cyc);
    check("ev_008_touch_hit", fr, 1);
    run_txn(1, 0, 32'h408, 0, 0, fr, got, cyc);
    check("ev_408_miss", fr, 0);
    check("ev_408_rdata", got, 32'h1111_1111);
    idle(1);
    run_txn(1, 0, 32'h008, 0, 0, fr, got, cyc);
    check("ev_008_kept", fr, 1);
    run_txn(1, 0, 32'h208, 0, 0, fr, got, cyc);
    check("ev_208_evicted", fr, 0);
    check("ev_miss_count", miss_count, STATS ? 32'd4 : 32'd0);

    // Write-through invalidates the cached line
    lat = 3;
    run_txn(1, 0, 32'h408, 0, 0, fr, got, cyc);
    nrd = rd_log.size();
    nwr = wr_addr_log.size();
    run_txn(0, 1, 32'h408, 32'hDEAD_BEEF, 0, fr, got, cyc);
    check("wr_first_ready", fr, 0);
    check("wr_latency", cyc, 4);
    check("wr_count", wr_addr_log.size(), nwr + 1);
    check("wr_no_read", rd_log.size(), nrd);
    if (wr_addr_log.size() > nwr) begin
      check("wr_addr", wr_addr_log[nwr], 32'h408);
      check("wr_data", wr_data_log[nwr], 32'hDEAD_BEEF);
    end
    run_txn(1, 0, 32'h408, 0, 0, fr, got, cyc);
    check("wr_reread_miss", fr, 0);
    check("wr_reread_data", got, 32'hDEAD_BEEF);
    run_txn(1, 0, 32'h40C, 0, 0, fr, got, cyc);
    check("wr_word1_hit", fr, 1);
    check("wr_word1_data", got, 32'h2222_2222);

    // Reset during the second SRAM read of a miss
    lat = 5;
    run_txn(1, 0, 32'h1230, 0, 1, fr, got, cyc);
    lat = 1;
    run_txn(1, 0, 32'h1230, 0, 0, fr, got, cyc);
    check("rstmid_same_miss", fr, 0);
    run_txn(1, 0, 32'h408, 0, 0, fr, got, cyc);
    check("rstmid_cleared_miss", fr, 0);

    // Simultaneous read and write requests behave as a write
    lat = 2;
    nrd = rd_log.size();
    nwr = wr_addr_log.size();
    run_txn(1, 1, 32'h40C, 32'hCAFE_F00D, 0, fr, got, cyc);
    check("both_first_ready", fr, 0);
    check("both_no_read", rd_log.size(), nrd);
    check("both_one_write", wr_addr_log.size(), nwr + 1);
    run_txn(1, 0, 32'h40C, 0, 0, fr, got, cyc);
    check("both_reread_miss", fr, 0);
    check("both_reread_data", got, 32'hCAFE_F00D);
    idle(3);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
